// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Recovers one byte per frame and signals either
// a one-cycle data_valid (good stop bit) or a one-cycle frame_err (stop bit low).
// Bits are sampled near mid-bit: the start bit is confirmed half a bit after the
// falling edge, then every following bit is sampled one full bit period later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  output logic [UART_DATA_BITS-1:0] byte_recv,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      rx_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      sync1;
  logic                      rx_s;
  logic                      prev;
  logic                      start_cond;
  rx_state_t                 state;
  logic [CW-1:0]             bit_cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shift;

  // A start needs a genuine high-to-low transition, so a line held low
  // through reset (break) cannot start a frame until it has gone high.
  assign start_cond = (rx_s == 1'b0) && (prev == 1'b1);

  // Two-flop synchroniser for the asynchronous line plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      rx_s  <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
      prev  <= rx_s;
    end
  end

  // Frame FSM: bit timing, data capture and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= CNT_ZERO;
      idx        <= 3'd0;
      shift      <= {UART_DATA_BITS{1'b0}};
      byte_recv  <= {UART_DATA_BITS{1'b0}};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the STOP decision raises them.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_cond) begin
            state     <= START;
            bit_cnt   <= CNT_ZERO;
            rx_active <= 1'b1;
          end else begin
            rx_active <= 1'b0;
          end
        end
        START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= CNT_ZERO;
            if (rx_s == 1'b0) begin
              state <= DATA;
              idx   <= 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt    <= CNT_ZERO;
            shift[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt   <= CNT_ZERO;
            state     <= DONE;
            rx_active <= 1'b0;
            if (rx_s == 1'b1) begin
              byte_recv  <= shift;
              data_valid <= 1'b1;
            end else begin
              // Bad stop bit: keep the previous good byte, report the error.
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bit_cnt   <= CNT_ZERO;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial driver produces frames,
// a monitor records every pulse, and each scenario compares against values
// derived from the frame timing rules and the bytes that were sent.
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 87;
  localparam int H            = (CLKS_PER_BIT - 1) / 2;
  localparam int STOP_EDGE    = H + 3 + 9 * CLKS_PER_BIT;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] byte_recv;
  logic       data_valid;
  logic       frame_err;
  logic       rx_active;

  int checks;
  int failures;
  int cyc;

  // Monitor records
  logic [7:0] got_q[$];
  int dv_cyc;
  int fe_cnt;
  int fe_cyc;
  int rise_cnt;
  int rise_cyc;
  int fall_cyc;
  logic act_prev;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .byte_recv  (byte_recv),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .rx_active  (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used as the time base for all timing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      got_q.push_back(byte_recv);
      dv_cyc <= cyc;
    end
    if (frame_err === 1'b1) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (rx_active === 1'b1 && act_prev !== 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (rx_active !== 1'b1 && act_prev === 1'b1) begin
      fall_cyc <= cyc;
    end
    act_prev <= rx_active;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial driver: start bit, 8 data bits LSB first, stop bit, each 'period' cycles.
  // base is the posedge count just before the falling edge, so edge e is seen at cyc = base+1+e.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period,
                            output int base);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    base = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (period) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rx_in = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);
    checks++;
    if (byte_recv !== 8'h00) begin
      failures++;
      $display("FAIL reset_byte: got %h want 00", byte_recv);
    end
    checks++;
    if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: got dv=%b fe=%b want 0 0", data_valid, frame_err);
    end
    checks++;
    if (rx_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active: got %b want 0", rx_active);
    end
    rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_exact_timing();
    int base;
    int n0;
    int fe0;
    n0  = got_q.size();
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1, CLKS_PER_BIT, base);
    wait_cycles(50);
    checks++;
    if (got_q.size() != n0 + 1) begin
      failures++;
      $display("FAIL timing_count: got %0d pulses want 1", got_q.size() - n0);
    end else begin
      checks++;
      if (got_q[n0] !== 8'h3C) begin
        failures++;
        $display("FAIL timing_byte: got %h want 3c", got_q[n0]);
      end
    end
    checks++;
    if (dv_cyc - base - 1 != STOP_EDGE) begin
      failures++;
      $display("FAIL timing_dv_edge: got %0d want %0d", dv_cyc - base - 1, STOP_EDGE);
    end
    checks++;
    if (rise_cyc - base - 1 != 2) begin
      failures++;
      $display("FAIL timing_active_rise: got %0d want 2", rise_cyc - base - 1);
    end
    checks++;
    if (fall_cyc - base - 1 != STOP_EDGE) begin
      failures++;
      $display("FAIL timing_active_fall: got %0d want %0d", fall_cyc - base - 1, STOP_EDGE);
    end
    checks++;
    if (fe_cnt != fe0) begin
      failures++;
      $display("FAIL timing_no_fe: got %0d want 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_loopback_a5();
    int base;
    int n0;
    int fe0;
    n0  = got_q.size();
    fe0 = fe_cnt;
    // Transmitter-style slow bit period (one extra cycle per bit).
    send_frame(8'hA5, 1'b1, CLKS_PER_BIT + 1, base);
    wait_cycles(30);
    checks++;
    if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'hA5) begin
      failures++;
      $display("FAIL loopback_a5: got %0d pulses last=%h want 1 pulse a5", got_q.size() - n0,
               byte_recv);
    end
    checks++;
    if (fe_cnt != fe0) begin
      failures++;
      $display("FAIL loopback_no_fe: got %0d want 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int base;
    int n0;
    int fe0;
    int r0;
    logic [7:0] good;
    good = 8'($urandom_range(0, 255));
    send_frame(good, 1'b1, CLKS_PER_BIT, base);
    wait_cycles(20);
    n0  = got_q.size();
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, CLKS_PER_BIT, base);
    wait_cycles(20);
    checks++;
    if (fe_cnt != fe0 + 1) begin
      failures++;
      $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0);
    end
    checks++;
    if (fe_cyc - base - 1 != STOP_EDGE) begin
      failures++;
      $display("FAIL ferr_edge: got %0d want %0d", fe_cyc - base - 1, STOP_EDGE);
    end
    checks++;
    if (got_q.size() != n0 || byte_recv !== good) begin
      failures++;
      $display("FAIL ferr_byte_kept: got %h (%0d new dv) want %h", byte_recv,
               got_q.size() - n0, good);
    end
    r0 = rise_cnt;
    wait_cycles(2000);
    checks++;
    if (rise_cnt != r0 || rx_active !== 1'b0) begin
      failures++;
      $display("FAIL break_no_start: got %0d rises want 0", rise_cnt - r0);
    end
    rx_in = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_glitch();
    int base;
    int n0;
    int fe0;
    int r0;
    n0  = got_q.size();
    fe0 = fe_cnt;
    r0  = rise_cnt;
    @(posedge clk);
    #1;
    base  = cyc;
    rx_in = 1'b0;
    wait_cycles(20);
    rx_in = 1'b1;
    wait_cycles(200);
    checks++;
    if (rise_cnt != r0 + 1) begin
      failures++;
      $display("FAIL glitch_rise: got %0d rises want 1", rise_cnt - r0);
    end
    checks++;
    if (fall_cyc - base - 1 != H + 3) begin
      failures++;
      $display("FAIL glitch_fall_edge: got %0d want %0d", fall_cyc - base - 1, H + 3);
    end
    checks++;
    if (got_q.size() != n0 || fe_cnt != fe0) begin
      failures++;
      $display("FAIL glitch_no_pulse: got dv=%0d fe=%0d want 0 0", got_q.size() - n0,
               fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    int n0;
    int fe0;
    int r0;
    logic [7:0] b;
    logic [8:0] bits;
    b    = 8'($urandom_range(0, 255)) & 8'hEF;
    bits = {b, 1'b0};
    n0   = got_q.size();
    fe0  = fe_cnt;
    @(posedge clk);
    #1;
    // start bit and data bits 0..3
    for (int i = 0; i < 5; i++) begin
      rx_in = bits[i];
      wait_cycles(CLKS_PER_BIT);
    end
    rx_in = 1'b0;  // bit 4 is low
    wait_cycles(40);
    rst_n = 1'b0;
    wait_cycles(5);
    rst_n = 1'b1;
    r0 = rise_cnt;
    wait_cycles(1200);
    checks++;
    if (got_q.size() != n0 || fe_cnt != fe0 || rise_cnt != r0 || rx_active !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got dv=%0d fe=%0d rises=%0d want 0 0 0",
               got_q.size() - n0, fe_cnt - fe0, rise_cnt - r0);
    end
    rx_in = 1'b1;
    wait_cycles(100);
    send_frame(8'h81, 1'b1, CLKS_PER_BIT, base);
    wait_cycles(20);
    checks++;
    if (got_q.size() != n0 + 1 || byte_recv !== 8'h81) begin
      failures++;
      $display("FAIL rst_mid_recover: got %0d pulses byte=%h want 1 pulse 81",
               got_q.size() - n0, byte_recv);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int n0;
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h55};
    n0 = got_q.size();
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, CLKS_PER_BIT + 1, base);
    wait_cycles(50);
    checks++;
    if (got_q.size() != n0 + 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 3", got_q.size() - n0);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[n0 + i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[n0 + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int base;
    int n0;
    int fe0;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic stop;
    n0  = got_q.size();
    fe0 = fe_cnt;
    for (int f = 0; f < 10; f++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      // Bit period within about +-3.5% of nominal.
      send_frame(b, stop, $urandom_range(CLKS_PER_BIT - 3, CLKS_PER_BIT + 3), base);
      if (stop) exp_q.push_back(b);
      else begin
        rx_in = 1'b1;
      end
      wait_cycles($urandom_range(2, 40));
    end
    wait_cycles(50);
    checks++;
    if (fe_cnt - fe0 != 10 - exp_q.size()) begin
      failures++;
      $display("FAIL rand_fe_count: got %0d want %0d", fe_cnt - fe0, 10 - exp_q.size());
    end
    checks++;
    if (got_q.size() != n0 + exp_q.size()) begin
      failures++;
      $display("FAIL rand_dv_count: got %0d want %0d", got_q.size() - n0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[n0 + i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_byte%0d: got %h want %h", i, got_q[n0 + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    fe_cnt   = 0;
    rise_cnt = 0;
    rise_cyc = 0;
    fall_cyc = 0;
    fe_cyc   = 0;
    dv_cyc   = 0;
    act_prev = 1'b0;
    rx_in    = 1'b1;
    rst_n    = 1'b0;
    test_reset();
    test_exact_timing();
    test_loopback_a5();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
